// File: rtl/gen_count_ctrl_if.sv
// Signal bundle between the generation sequencer, the raw buttons, the Life engine
// handshake and the display-facing status outputs.
interface gen_count_ctrl_if;
    logic        btn_run;
    logic        btn_step;
    logic        btn_clr;
    logic        gen_done;
    logic        gen_start;
    logic        running;
    logic [13:0] num;

    modport master (
        input  btn_run,
        input  btn_step,
        input  btn_clr,
        input  gen_done,
        output gen_start,
        output running,
        output num
    );

    modport slave (
        output btn_run,
        output btn_step,
        output btn_clr,
        output gen_done,
        input  gen_start,
        input  running,
        input  num
    );
endinterface

// File: rtl/gen_count_ctrl.sv
// Generation sequencer for the Life engine: debounced buttons, start/done pacing of the
// engine and a wrapping count of completed generations for the 7-segment display.

module gen_count_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock_100,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles the synchronized level disagrees with the accepted one
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;
endmodule

// state   | meaning
// S_IDLE  | between generations; period timer runs while running, step accepted while paused
// S_START | gen_start asserted for this single cycle
// S_WAIT  | engine busy; waiting for gen_done
module gen_count_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned GEN_PERIOD      = 50000000,
    parameter int unsigned MAX_COUNT       = 9999
) (
    input logic              clock_100,
    input logic              reset,
    gen_count_ctrl_if.master bus
);
    localparam int unsigned   TW         = $clog2(GEN_PERIOD + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GEN_PERIOD - 1);
    localparam logic [13:0]   NUM_MAX    = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          count_inc;
    logic          running_q;
    logic [13:0]   num_q;
    logic          run_p;
    logic          step_p;
    logic          clr_p;

    gen_count_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clock_100 (clock_100),
        .reset     (reset),
        .raw       (bus.btn_run),
        .press     (run_p)
    );

    gen_count_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clock_100 (clock_100),
        .reset     (reset),
        .raw       (bus.btn_step),
        .press     (step_p)
    );

    gen_count_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clock_100 (clock_100),
        .reset     (reset),
        .raw       (bus.btn_clr),
        .press     (clr_p)
    );

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        count_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (running_q) begin
                    if (timer == TIMER_LAST) begin
                        state_nxt = S_START;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end else begin
                    timer_nxt = '0;
                    if (step_p) begin
                        state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // a pause requested meanwhile only takes effect once back in S_IDLE
                if (bus.gen_done) begin
                    count_inc = 1'b1;
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            running_q <= 1'b0;
        end else begin
            running_q <= running_q ^ run_p;
        end
    end

    // clear has priority over a generation completing in the same cycle
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            num_q <= '0;
        end else if (clr_p) begin
            num_q <= '0;
        end else if (count_inc) begin
            num_q <= (num_q == NUM_MAX) ? 14'd0 : num_q + 14'd1;
        end
    end

    assign bus.gen_start = (state == S_START);
    assign bus.running   = running_q;
    assign bus.num       = num_q;
endmodule

// File: tb/tb_gen_count_ctrl.sv
// Bench for gen_count_ctrl: two instances (normal and small wrap limit), an engine model
// answering gen_start, and a counting model of the expected generation number.
module tb_gen_count_ctrl;
    localparam int D     = 4;
    localparam int G     = 8;
    localparam int MAX_A = 9999;
    localparam int MAX_B = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gen_count_ctrl_if ifa ();
    gen_count_ctrl_if ifb ();

    logic eng_a = 1'b0, man_a = 1'b0, eng_b = 1'b0, man_b = 1'b0;
    assign ifa.gen_done = eng_a | man_a;
    assign ifb.gen_done = eng_b | man_b;

    gen_count_ctrl #(.DEBOUNCE_CYCLES(D), .GEN_PERIOD(G), .MAX_COUNT(MAX_A)) dut_a (
        .clock_100 (clk),
        .reset     (reset),
        .bus       (ifa)
    );

    gen_count_ctrl #(.DEBOUNCE_CYCLES(D), .GEN_PERIOD(G), .MAX_COUNT(MAX_B)) dut_b (
        .clock_100 (clk),
        .reset     (reset),
        .bus       (ifb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts_a = 0;
    int starts_b = 0;
    int start_cyc_a[$];
    int nums_b[$];
    int lat_a = 3;
    int lat_b = 3;
    bit manual_a = 1'b0;
    bit manual_b = 1'b0;
    int exp_a = 0;
    int s0;
    int base;
    int n;
    int act;
    int hi;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input bit inst_b, input int b, input logic v);
        if (!inst_b) begin
            case (b)
                0:       ifa.btn_run  = v;
                1:       ifa.btn_step = v;
                default: ifa.btn_clr  = v;
            endcase
        end else begin
            case (b)
                0:       ifb.btn_run  = v;
                1:       ifb.btn_step = v;
                default: ifb.btn_clr  = v;
            endcase
        end
    endtask

    task automatic press(input bit inst_b, input int b, input int hold, input int rest);
        set_btn(inst_b, b, 1'b1);
        tick(hold);
        set_btn(inst_b, b, 1'b0);
        tick(rest);
    endtask

    function automatic int next_count(input int v, input int max);
        return (v + 1) % (max + 1);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (ifa.gen_start) begin
            starts_a++;
            start_cyc_a.push_back(cyc);
        end
        if (ifb.gen_start) starts_b++;
    end

    // Engine model: gen_done lands L+1 cycles after the gen_start cycle, giving a
    // running cadence of G + 2 + L cycles.
    initial forever begin
        @(negedge clk);
        if (ifa.gen_start && !manual_a) begin
            repeat (lat_a + 1) @(posedge clk);
            #1 eng_a = 1'b1;
            @(posedge clk);
            #1 eng_a = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifb.gen_start && !manual_b) begin
            repeat (lat_b + 1) @(posedge clk);
            #1 eng_b = 1'b1;
            @(posedge clk);
            #1 eng_b = 1'b0;
            nums_b.push_back(int'(ifb.num));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ifa.btn_run = 1'b0; ifa.btn_step = 1'b0; ifa.btn_clr = 1'b0;
        ifb.btn_run = 1'b0; ifb.btn_step = 1'b0; ifb.btn_clr = 1'b0;
        tick(3);
        check_val("rst_num", int'(ifa.num), 0);
        check_val("rst_running", int'(ifa.running), 0);
        check_val("rst_gen_start", int'(ifa.gen_start), 0);
        reset = 1'b0;
        tick(2);

        // long step hold: one generation only
        lat_a = 3;
        press(1'b0, 1, 20, 20);
        exp_a = next_count(exp_a, MAX_A);
        check_val("t1_starts", starts_a, 1);
        check_val("t1_num", int'(ifa.num), exp_a);
        check_val("t1_running", int'(ifa.running), 0);

        // short glitches are rejected
        for (int i = 0; i < 4; i++) press(1'b0, 1, int'($urandom_range(D - 1, 1)), 10);
        check_val("t2_glitch_starts", starts_a, 1);
        check_val("t2_glitch_num", int'(ifa.num), exp_a);

        // second step press lands while the engine is still busy
        lat_a = 20;
        s0 = starts_a;
        press(1'b0, 1, 8, 8);
        press(1'b0, 1, 8, 8);
        tick(30);
        exp_a = next_count(exp_a, MAX_A);
        check_val("t2_drop_starts", starts_a, s0 + 1);
        check_val("t2_drop_num", int'(ifa.num), exp_a);

        // free-running cadence
        lat_a = 3;
        s0 = starts_a;
        base = start_cyc_a.size();
        press(1'b0, 0, 8, 0);
        check_val("t3_running_on", int'(ifa.running), 1);
        n = 0;
        while (starts_a < s0 + 5 && n < 200) begin tick(1); n++; end
        check_val("t3_five_starts", int'(starts_a >= s0 + 5), 1);
        if (start_cyc_a.size() >= base + 5) begin
            for (int k = 1; k < 5; k++)
                check_val($sformatf("t3_spacing%0d", k),
                          start_cyc_a[base + k] - start_cyc_a[base + k - 1], G + 2 + lat_a);
        end
        tick(6);
        for (int k = 0; k < 5; k++) exp_a = next_count(exp_a, MAX_A);
        check_val("t3_num5", int'(ifa.num), exp_a);

        // pause in the middle of a generation: it still counts, then nothing more
        lat_a = 12;
        n = 0;
        while (!ifa.gen_start && n < 30) begin tick(1); n++; end
        check_val("t3_sixth_start", int'(ifa.gen_start), 1);
        press(1'b0, 0, 8, 30);
        exp_a = next_count(exp_a, MAX_A);
        check_val("t3_paused", int'(ifa.running), 0);
        check_val("t3_total_starts", starts_a, s0 + 6);
        check_val("t3_num6", int'(ifa.num), exp_a);

        // random step / glitch / clear mix while paused
        for (int i = 0; i < 10; i++) begin
            act = int'($urandom_range(2, 0));
            lat_a = int'($urandom_range(6, 1));
            s0 = starts_a;
            case (act)
                0: begin
                    hi = int'($urandom_range(10, D));
                    press(1'b0, 1, hi, 12 + lat_a);
                    exp_a = next_count(exp_a, MAX_A);
                    s0 = s0 + 1;
                end
                1: begin
                    hi = int'($urandom_range(D - 1, 1));
                    press(1'b0, 1, hi, 12);
                end
                default: begin
                    hi = int'($urandom_range(10, D));
                    press(1'b0, 2, hi, 12);
                    exp_a = 0;
                end
            endcase
            tick(lat_a + 4);
            check_val($sformatf("rnd%0d_act%0d_num", i, act), int'(ifa.num), exp_a);
            check_val($sformatf("rnd%0d_act%0d_starts", i, act), starts_a, s0);
        end

        // wrap at MAX_COUNT=3 on the second instance
        lat_b = 3;
        press(1'b1, 0, 8, 0);
        n = 0;
        while (nums_b.size() < 5 && n < 200) begin tick(1); n++; end
        manual_b = 1'b1;
        check_val("t4_five_done", int'(nums_b.size() >= 5), 1);
        if (nums_b.size() >= 5) begin
            for (int k = 0; k < 5; k++)
                check_val($sformatf("t4_wrap%0d", k), nums_b[k], (k + 1) % (MAX_B + 1));
        end

        // clear press coinciding with gen_done: clear wins
        n = 0;
        while (!ifb.gen_start && n < 30) begin tick(1); n++; end
        check_val("t4_start_for_clr", int'(ifb.gen_start), 1);
        set_btn(1'b1, 2, 1'b1);
        tick(2 + D);
        man_b = 1'b1;
        tick(1);
        man_b = 1'b0;
        check_val("t4_clr_wins", int'(ifb.num), 0);
        check_val("t4_clr_keeps_running", int'(ifb.running), 1);
        set_btn(1'b1, 2, 1'b0);
        tick(10);
        check_val("t4_num_after_clr", int'(ifb.num), 0);

        // reach num=7, hang in S_WAIT, then reset
        lat_a = 2;
        press(1'b0, 2, 8, 12);
        exp_a = 0;
        for (int i = 0; i < 7; i++) begin
            press(1'b0, 1, 8, 14);
            exp_a = next_count(exp_a, MAX_A);
        end
        check_val("t5_num7", int'(ifa.num), exp_a);
        manual_a = 1'b1;
        press(1'b0, 1, 8, 0);
        reset = 1'b1;
        #1;
        check_val("t5_rst_num", int'(ifa.num), 0);
        check_val("t5_rst_running", int'(ifa.running), 0);
        check_val("t5_rst_gen_start", int'(ifa.gen_start), 0);
        tick(3);
        reset = 1'b0;
        s0 = starts_a;
        tick(2);
        man_a = 1'b1;
        tick(1);
        man_a = 1'b0;
        tick(20);
        check_val("t5_late_done_num", int'(ifa.num), 0);
        check_val("t5_late_done_starts", starts_a, s0);
        check_val("t5_late_done_running", int'(ifa.running), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
